// File: rtl/memi_multiport.sv
// Multi-port instruction memory: NUM_RD read ports with fixed RD_LAT latency, a program-load write port,
// and a post-reset fill engine. Define MEMI_MULTIPORT_WR_BYPASS_EN for write-first same-address reads.
//
// state  | meaning
// S_FILL | fill engine writes FILL_WORD to every entry; ports not ready, writes dropped
// S_RUN  | normal operation until the next rst
module memi_multiport #(
    parameter int                 DATA_W    = 16,
    parameter int                 DEPTH     = 8,
    parameter int                 ADDR_W    = $clog2(DEPTH),
    parameter int                 NUM_RD    = 2,
    parameter int                 RD_LAT    = 1,
    parameter logic [DATA_W-1:0]  FILL_WORD = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_err,
    input  logic [NUM_RD-1:0]          rd_req_valid,
    output logic [NUM_RD-1:0]          rd_req_ready,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_req_addr,
    output logic [NUM_RD-1:0]          rd_resp_valid,
    output logic [NUM_RD*DATA_W-1:0]   rd_resp_data,
    output logic [NUM_RD-1:0]          rd_resp_err
);

    typedef enum logic {S_FILL, S_RUN} state_t;

    // One extra bit so that DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    state_t              state;
    logic [ADDR_W-1:0]   fill_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_ok;

    assign wr_ok = wr_en && !init_busy && in_range(wr_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FILL;
            fill_cnt  <= '0;
            init_busy <= 1'b1;
            wr_err    <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
            case (state)
                S_FILL: begin
                    if (fill_cnt == LAST) begin
                        state     <= S_RUN;
                        init_busy <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The array has no reset; the fill engine rewrites every entry after each reset release.
    always_ff @(posedge clk) begin
        if (state == S_FILL) begin
            mem[fill_cnt] <= FILL_WORD;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0]  addr;
        logic               acc;
        logic               oor;
        logic [DATA_W-1:0]  word;
        logic [RD_LAT-1:0]  pv;
        logic [RD_LAT-1:0]  pe;
        logic [DATA_W-1:0]  pd [RD_LAT];

        assign addr = rd_req_addr[p*ADDR_W +: ADDR_W];
        assign acc  = rd_req_valid[p] && !init_busy;
        assign oor  = !in_range(addr);

        always_comb begin
            word = '0;
            if (!oor) begin
                word = mem[addr];
`ifdef MEMI_MULTIPORT_WR_BYPASS_EN
                if (wr_ok && (wr_addr == addr)) begin
                    word = wr_data;
                end
`endif
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv <= '0;
                pe <= '0;
                for (int i = 0; i < RD_LAT; i++) begin
                    pd[i] <= '0;
                end
            end else begin
                pv[0] <= acc;
                pe[0] <= acc && oor;
                pd[0] <= acc ? word : '0;
                for (int i = 1; i < RD_LAT; i++) begin
                    pv[i] <= pv[i-1];
                    pe[i] <= pe[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end

        assign rd_req_ready[p]                   = !init_busy;
        assign rd_resp_valid[p]                  = pv[RD_LAT-1];
        assign rd_resp_err[p]                    = pe[RD_LAT-1];
        assign rd_resp_data[p*DATA_W +: DATA_W]  = pd[RD_LAT-1];
    end

endmodule

// File: tb/tb_memi_multiport.sv
// Self-checking bench for memi_multiport: directed steps plus random traffic against a queue-based reference.
module tb_memi_multiport;

    localparam int               DW     = 16;
    localparam int               DEPTH  = 6;
    localparam int               AW     = 3;
    localparam int               NUM_RD = 2;
    localparam int               RD_LAT = 3;
    localparam logic [DW-1:0]    FILLW  = 16'h0F0F;
`ifdef MEMI_MULTIPORT_WR_BYPASS_EN
    localparam bit               BYPASS = 1'b1;
`else
    localparam bit               BYPASS = 1'b0;
`endif

    logic                    clk;
    logic                    rst;
    logic                    init_busy;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [DW-1:0]           wr_data;
    logic                    wr_err;
    logic [NUM_RD-1:0]       rd_req_valid;
    logic [NUM_RD-1:0]       rd_req_ready;
    logic [NUM_RD*AW-1:0]    rd_req_addr;
    logic [NUM_RD-1:0]       rd_resp_valid;
    logic [NUM_RD*DW-1:0]    rd_resp_data;
    logic [NUM_RD-1:0]       rd_resp_err;

    memi_multiport #(
        .DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .RD_LAT(RD_LAT), .FILL_WORD(FILLW)
    ) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    // Reference: plain array for contents, fill progress counter, expected responses tagged with due cycle.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_fill;
    bit            m_busy;
    bit            m_wr_err;
    resp_t         q [NUM_RD][$];
    int            cyc;
    int            n_vec;
    int            n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit            wok;
        logic [AW-1:0] a;
        resp_t         r;
        wok      = wr_en && !m_busy && (int'(wr_addr) < DEPTH);
        m_wr_err = wr_en && !wok;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_req_valid[p] && !m_busy) begin
                a     = rd_req_addr[p*AW +: AW];
                r.due = cyc + RD_LAT;
                if (int'(a) >= DEPTH) begin
                    r.data = '0;
                    r.err  = 1'b1;
                end else begin
                    r.data = (BYPASS && wok && wr_addr == a) ? wr_data : m_mem[a];
                    r.err  = 1'b0;
                end
                q[p].push_back(r);
            end
        end
        if (wok) m_mem[wr_addr] = wr_data;
        if (m_busy) begin
            m_mem[m_fill] = FILLW;
            m_fill++;
            if (m_fill == DEPTH) m_busy = 1'b0;
        end
    endtask

    task automatic check_outputs();
        resp_t r;
        chk("init_busy", 32'(init_busy), 32'(m_busy));
        chk("rd_req_ready", 32'(rd_req_ready), m_busy ? 32'd0 : 32'((1 << NUM_RD) - 1));
        chk("wr_err", 32'(wr_err), 32'(m_wr_err));
        for (int p = 0; p < NUM_RD; p++) begin
            if (q[p].size() > 0 && q[p][0].due == cyc) begin
                r = q[p].pop_front();
                chk($sformatf("resp_valid[%0d]", p), 32'(rd_resp_valid[p]), 32'd1);
                chk($sformatf("resp_data[%0d]", p), 32'(rd_resp_data[p*DW +: DW]), 32'(r.data));
                chk($sformatf("resp_err[%0d]", p), 32'(rd_resp_err[p]), 32'(r.err));
            end else begin
                chk($sformatf("resp_idle[%0d]", p), 32'(rd_resp_valid[p]), 32'd0);
            end
        end
    endtask

    task automatic tick();
        if (!rst) model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle();
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        rd_req_valid = '0;
        rd_req_addr  = '0;
    endtask

    task automatic drive_rd(input int p, input bit v, input int a);
        rd_req_valid[p]          = v;
        rd_req_addr[p*AW +: AW]  = AW'(a);
    endtask

    task automatic drive_wr(input bit e, input int a, input logic [DW-1:0] d);
        wr_en   = e;
        wr_addr = AW'(a);
        wr_data = d;
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        #1;
        m_busy   = 1'b1;
        m_fill   = 0;
        m_wr_err = 1'b0;
        for (int p = 0; p < NUM_RD; p++) q[p].delete();
        check_outputs();
        chk("rst_resp_data", 32'(rd_resp_data), 32'd0);
        chk("rst_resp_err", 32'(rd_resp_err), 32'd0);
        repeat (hold) tick();
        idle();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (RD_LAT + 1) tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b0;
        idle();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        #2;
        apply_reset(2);

        // Fill window: requests and writes are refused for exactly DEPTH cycles.
        drive_rd(0, 1'b1, 1);
        drive_rd(1, 1'b1, 2);
        drive_wr(1'b1, 0, 16'h1234);
        repeat (DEPTH) tick();
        idle();

        // Every address on both ports, including the two out-of-range codes.
        for (int i = 0; i < 8; i++) begin
            drive_rd(0, 1'b1, i);
            drive_rd(1, 1'b1, 7 - i);
            tick();
        end
        drain();

        drive_wr(1'b1, 3, 16'hA5A5);
        tick();
        idle();
        drive_rd(0, 1'b1, 3);
        tick();
        drain();

        drive_wr(1'b1, 5, 16'h1111);
        tick();
        drive_wr(1'b1, 4, 16'h2222);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            drive_rd(0, 1'b1, 5);
            drive_rd(1, 1'b1, 4);
            tick();
        end
        drain();

        // Same-cycle write and read of one address.
        drive_wr(1'b1, 2, 16'hBEEF);
        drive_rd(0, 1'b1, 2);
        drive_rd(1, 1'b1, 2);
        tick();
        idle();
        drive_rd(0, 1'b1, 2);
        tick();
        drain();

        drive_wr(1'b1, 6, 16'hDEAD);
        tick();
        drive_wr(1'b1, 7, 16'hDEAD);
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            drive_rd(0, 1'b1, i);
            tick();
        end
        drain();

        for (int n = 0; n < 200; n++) begin
            for (int p = 0; p < NUM_RD; p++) drive_rd(p, $urandom_range(0, 1) == 1, $urandom_range(0, 7));
            drive_wr($urandom_range(0, 2) == 0, $urandom_range(0, 7), DW'($urandom));
            tick();
        end
        drain();

        // Reset with a read in flight and a write pending.
        drive_wr(1'b1, 1, 16'hCAFE);
        tick();
        idle();
        drive_rd(0, 1'b1, 1);
        tick();
        idle();
        tick();
        drive_wr(1'b1, 0, 16'hDEAD);
        apply_reset(2);
        repeat (DEPTH + 1) tick();
        drive_rd(0, 1'b1, 1);
        drive_rd(1, 1'b1, 0);
        tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
